// File: rtl/game_screen_ctrl_if.sv
// Bus between the keyboard/video side and the game-screen controller.
// The master drives key, frame, death and pixel inputs; the slave returns the screen state and banner overlay.
interface game_screen_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic [7:0]        keycode;
    logic              Frame_Tick;
    logic              Player_Dead;
    logic [8:0]        PixelX;
    logic [8:0]        PixelY;
    logic [1:0]        Screen_State;
    logic              Game_Run;
    logic              is_obj;
    logic [ADDR_W-1:0] Obj_address;

    modport master (
        output keycode, Frame_Tick, Player_Dead, PixelX, PixelY,
        input  Screen_State, Game_Run, is_obj, Obj_address
    );

    modport slave (
        input  keycode, Frame_Tick, Player_Dead, PixelX, PixelY,
        output Screen_State, Game_Run, is_obj, Obj_address
    );
endinterface

// File: rtl/game_screen_ctrl.sv
// Game-screen flow FSM (START/PLAYING/PAUSED/OVER) with a registered banner overlay from one packed ROM.
// Define GAME_SCREEN_BLINK_EN to blink the START and OVER banners every BLINK_FRAMES frames.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_START | title banner shown, waiting for start key
// ST_PLAY  | game running, no banner
// ST_PAUSE | pause banner shown, pause/start resumes
// ST_OVER  | game-over banner shown, restart key -> START
module game_screen_ctrl #(
    parameter int W            = 180,
    parameter int H            = 30,
    parameter int X_CENTER     = 160,
    parameter int Y_CENTER     = 80,
    parameter int ADDR_W       = 18,
    parameter int KEY_START    = 44,
    parameter int KEY_PAUSE    = 19,
    parameter int KEY_RESTART  = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset_n,
    game_screen_ctrl_if.slave bus
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [8:0] XPOS = 9'(X_CENTER - W / 2);
    localparam logic [8:0] YPOS = 9'(Y_CENTER - H / 2);
    localparam logic [9:0] XEND = {1'b0, XPOS} + 10'(W);
    localparam logic [9:0] YEND = {1'b0, YPOS} + 10'(H);

    localparam logic [7:0] K_START   = 8'(KEY_START);
    localparam logic [7:0] K_PAUSE   = 8'(KEY_PAUSE);
    localparam logic [7:0] K_RESTART = 8'(KEY_RESTART);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [7:0]        key_prev;
    logic              ev_start;
    logic              ev_pause;
    logic              ev_restart;
    logic              hit;
    logic              banner_off;
    logic [1:0]        idx;
    logic [8:0]        dx;
    logic [8:0]        dy;
    logic [ADDR_W-1:0] addr_calc;

    // A key counts only on the cycle it first appears; code 0 is "no key".
    assign ev_start   = (bus.keycode != 8'd0) && (bus.keycode == K_START)   && (key_prev != K_START);
    assign ev_pause   = (bus.keycode != 8'd0) && (bus.keycode == K_PAUSE)   && (key_prev != K_PAUSE);
    assign ev_restart = (bus.keycode != 8'd0) && (bus.keycode == K_RESTART) && (key_prev != K_RESTART);

    always_comb begin
        state_next = state;
        case (state)
            ST_START: if (ev_start) state_next = ST_PLAY;
            ST_PLAY: begin
                if (bus.Player_Dead)  state_next = ST_OVER;
                else if (ev_pause)    state_next = ST_PAUSE;
            end
            ST_PAUSE: if (ev_pause || ev_start) state_next = ST_PLAY;
            ST_OVER:  if (ev_restart) state_next = ST_START;
            default:  state_next = ST_START;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_START;
            key_prev <= 8'd0;
        end else begin
            state    <= state_next;
            key_prev <= bus.keycode;
        end
    end

    assign bus.Screen_State = state;
    assign bus.Game_Run     = (state == ST_PLAY);

`ifdef GAME_SCREEN_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_hidden;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt    <= 8'd0;
            blink_hidden <= 1'b0;
        end else if (state_next != state) begin
            blink_cnt    <= 8'd0;
            blink_hidden <= 1'b0;
        end else if (bus.Frame_Tick) begin
            if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt    <= 8'd0;
                blink_hidden <= ~blink_hidden;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    // The pause banner stays solid so a paused game is always obvious.
    assign banner_off = blink_hidden && ((state == ST_START) || (state == ST_OVER));
`else
    logic unused_frame_tick;
    assign unused_frame_tick = bus.Frame_Tick;
    assign banner_off        = 1'b0;
`endif

    always_comb begin
        idx = 2'd0;
        case (state)
            ST_PAUSE: idx = 2'd1;
            ST_OVER:  idx = 2'd2;
            default:  idx = 2'd0;
        endcase
    end

    assign dx  = bus.PixelX - XPOS;
    assign dy  = bus.PixelY - YPOS;
    assign hit = ({1'b0, bus.PixelX} >= {1'b0, XPOS}) && ({1'b0, bus.PixelX} < XEND) &&
                 ({1'b0, bus.PixelY} >= {1'b0, YPOS}) && ({1'b0, bus.PixelY} < YEND) &&
                 (state != ST_PLAY) && !banner_off;

    // Banners sit back to back in the ROM, W*H words each, indexed by screen.
    assign addr_calc = ADDR_W'(idx) * ADDR_W'(W * H) + ADDR_W'(dy) * ADDR_W'(W) + ADDR_W'(dx);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.is_obj      <= 1'b0;
            bus.Obj_address <= '0;
        end else begin
            bus.is_obj      <= hit;
            bus.Obj_address <= hit ? addr_calc : '0;
        end
    end

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl: screen flow, key edges, banner geometry and async reset.
// Blink checks run only when GAME_SCREEN_BLINK_EN is defined (DUT built with BLINK_FRAMES=2).
module tb_game_screen_ctrl;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   errors;

    game_screen_ctrl_if #(.ADDR_W(18)) bus ();

    game_screen_ctrl #(.BLINK_FRAMES(2)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        bus.PixelX = 9'(x);
        bus.PixelY = 9'(y);
    endtask

    task automatic test_reset();
        Reset_n         = 1'b0;
        bus.keycode     = 8'd0;
        bus.Frame_Tick  = 1'b0;
        bus.Player_Dead = 1'b0;
        set_pix(0, 0);
        #12;
        checks++; if (bus.Screen_State !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.Screen_State); end
        checks++; if (bus.Game_Run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", bus.Game_Run); end
        checks++; if (bus.is_obj !== 1'b0 || bus.Obj_address !== 18'd0) begin errors++; $display("FAIL reset_obj got %b/%0d want 0/0", bus.is_obj, bus.Obj_address); end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_banner_start();
        set_pix(70, 65); tick();
        checks++; if (bus.is_obj !== 1'b1 || bus.Obj_address !== 18'd0) begin errors++; $display("FAIL start_first got %b/%0d want 1/0", bus.is_obj, bus.Obj_address); end
        set_pix(249, 94); tick();
        checks++; if (bus.is_obj !== 1'b1 || bus.Obj_address !== 18'd5399) begin errors++; $display("FAIL start_last got %b/%0d want 1/5399", bus.is_obj, bus.Obj_address); end
        set_pix(250, 94); tick();
        checks++; if (bus.is_obj !== 1'b0 || bus.Obj_address !== 18'd0) begin errors++; $display("FAIL x_end_miss got %b/%0d want 0/0", bus.is_obj, bus.Obj_address); end
        set_pix(249, 95); tick();
        checks++; if (bus.is_obj !== 1'b0 || bus.Obj_address !== 18'd0) begin errors++; $display("FAIL y_end_miss got %b/%0d want 0/0", bus.is_obj, bus.Obj_address); end
        set_pix(69, 65); tick();
        checks++; if (bus.is_obj !== 1'b0) begin errors++; $display("FAIL x_low_miss got %b want 0", bus.is_obj); end
        bus.keycode = 8'd19; tick();
        checks++; if (bus.Screen_State !== 2'd0) begin errors++; $display("FAIL start_ignores_pause got %0d want 0", bus.Screen_State); end
        bus.keycode = 8'd0; tick();
    endtask

    task automatic test_start_held();
        bus.keycode = 8'd44;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.Screen_State !== 2'd1 || bus.Game_Run !== 1'b1) begin errors++; $display("FAIL start_held[%0d] got %0d/%b want 1/1", i, bus.Screen_State, bus.Game_Run); end
        end
        set_pix(70, 65); tick();
        checks++; if (bus.is_obj !== 1'b0) begin errors++; $display("FAIL play_no_banner got %b want 0", bus.is_obj); end
        bus.keycode = 8'd0; tick();
    endtask

    task automatic test_pause();
        bus.keycode = 8'd19; tick();
        checks++; if (bus.Screen_State !== 2'd2 || bus.Game_Run !== 1'b0) begin errors++; $display("FAIL pause_enter got %0d/%b want 2/0", bus.Screen_State, bus.Game_Run); end
        bus.keycode = 8'd0; set_pix(70, 65); tick();
        checks++; if (bus.is_obj !== 1'b1 || bus.Obj_address !== 18'd5400) begin errors++; $display("FAIL pause_banner got %b/%0d want 1/5400", bus.is_obj, bus.Obj_address); end
        bus.Player_Dead = 1'b1; tick();
        bus.Player_Dead = 1'b0;
        checks++; if (bus.Screen_State !== 2'd2) begin errors++; $display("FAIL pause_ignores_dead got %0d want 2", bus.Screen_State); end
        bus.keycode = 8'd19; tick();
        checks++; if (bus.Screen_State !== 2'd1) begin errors++; $display("FAIL pause_resume got %0d want 1", bus.Screen_State); end
        tick();
        checks++; if (bus.Screen_State !== 2'd1) begin errors++; $display("FAIL held_no_repause got %0d want 1", bus.Screen_State); end
    endtask

    task automatic test_dead_priority();
        bus.keycode = 8'd0; tick();
        bus.keycode = 8'd19; bus.Player_Dead = 1'b1; tick();
        bus.Player_Dead = 1'b0;
        checks++; if (bus.Screen_State !== 2'd3 || bus.Game_Run !== 1'b0) begin errors++; $display("FAIL dead_priority got %0d/%b want 3/0", bus.Screen_State, bus.Game_Run); end
        set_pix(71, 66); tick();
        checks++; if (bus.is_obj !== 1'b1 || bus.Obj_address !== 18'd10981) begin errors++; $display("FAIL over_banner got %b/%0d want 1/10981", bus.is_obj, bus.Obj_address); end
        bus.keycode = 8'd44; tick();
        checks++; if (bus.Screen_State !== 2'd3) begin errors++; $display("FAIL over_ignores_start got %0d want 3", bus.Screen_State); end
        bus.keycode = 8'd40; tick();
        checks++; if (bus.Screen_State !== 2'd0) begin errors++; $display("FAIL restart got %0d want 0", bus.Screen_State); end
        tick();
        checks++; if (bus.Screen_State !== 2'd0) begin errors++; $display("FAIL restart_no_chain got %0d want 0", bus.Screen_State); end
        bus.keycode = 8'd0; tick();
    endtask

    task automatic test_async_reset();
        bus.keycode = 8'd44; tick();
        bus.keycode = 8'd19; tick();
        set_pix(70, 65); tick();
        checks++; if (bus.Screen_State !== 2'd2 || bus.is_obj !== 1'b1) begin errors++; $display("FAIL pre_reset got %0d/%b want 2/1", bus.Screen_State, bus.is_obj); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (bus.Screen_State !== 2'd0 || bus.is_obj !== 1'b0 || bus.Obj_address !== 18'd0) begin errors++; $display("FAIL async_reset got %0d/%b/%0d want 0/0/0", bus.Screen_State, bus.is_obj, bus.Obj_address); end
        bus.keycode = 8'd0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

`ifdef GAME_SCREEN_BLINK_EN
    task automatic test_blink();
        set_pix(70, 65);
        for (int n = 1; n <= 8; n++) begin
            bus.Frame_Tick = 1'b1; tick();
            bus.Frame_Tick = 1'b0; tick();
            checks++; if (bus.is_obj !== (((n / 2) % 2) == 0)) begin errors++; $display("FAIL blink_start[%0d] got %b want %b", n, bus.is_obj, ((n / 2) % 2) == 0); end
        end
        bus.keycode = 8'd44; tick();
        bus.keycode = 8'd19; tick();
        bus.keycode = 8'd0;
        for (int n = 1; n <= 4; n++) begin
            bus.Frame_Tick = 1'b1; tick();
            bus.Frame_Tick = 1'b0; tick();
            checks++; if (bus.is_obj !== 1'b1) begin errors++; $display("FAIL blink_pause[%0d] got %b want 1", n, bus.is_obj); end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_banner_start();
        test_start_held();
        test_pause();
        test_dead_priority();
        test_async_reset();
`ifdef GAME_SCREEN_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
